// File: rtl/i2c_reg_target.sv
`timescale 1ns/1ps
// i2c_reg_target
// I2C target (slave) exposing four 8-bit registers.
//   First byte written after the address sets the register pointer; further
//   written bytes land in reg[ptr] with pointer auto-increment (wraps 3->0).
//   Reads return reg[ptr] and advance the pointer on every master ACK.
//   The pointer persists across transactions.
// Ports:
//   clk       system clock, rising edge (must be >= 8x SCL)
//   rst       asynchronous active-low reset
//   scl       I2C clock input (never driven)
//   sda       open-drain I2C data, driven only to 0 or Z
//   regs      register file, reg[i] at bits [8i+7:8i]
//   wr_pulse  one-clk strobe per register write
//   wr_idx    index of the register written (valid with wr_pulse)
//   wr_data   data written (valid with wr_pulse)
//   busy      high from our address ACK until STOP, repeated START or read NACK
module i2c_reg_target #(
    parameter logic [6:0] OWN_ADDR    = 7'b1010001,
    parameter int         SYNC_STAGES = 2            // must be >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [31:0] regs,
    output logic        wr_pulse,
    output logic [1:0]  wr_idx,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE,
        S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
    } state_t;

    // ---------------- synchronizers and edge detection ----------------
    // Flops idle at 1 so reset release never looks like a START.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_d1_q, sda_d1_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_d1_q   <= scl_s;
            sda_d1_q   <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d1_q;
    assign scl_fall  = ~scl_s &  scl_d1_q;
    assign start_det =  scl_s &  sda_d1_q & ~sda_s;
    assign stop_det  =  scl_s & ~sda_d1_q &  sda_s;

    // ---------------- protocol state ----------------
    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    // Only 7 bits are held: RX appends the live SDA bit to form a byte,
    // TX drives bit 7 straight from the register on load.
    logic [6:0]  shift_q, shift_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [31:0] regs_q, regs_d;
    logic        sda_oe_q, sda_oe_d;     // 1 = pull SDA low
    logic        busy_q, busy_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rw_q, rw_d;
    // ACK states span two SCL falls (or a rise then a fall); phase marks the second half.
    logic        phase_q, phase_d;
    logic        first_q, first_d;       // next RX byte is the pointer byte

    logic [7:0]  rx_byte, cur_reg;
    assign rx_byte = {shift_q, sda_s};
    assign cur_reg = regs_q[{ptr_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 7'd0;
            ptr_q      <= 2'd0;
            regs_q     <= 32'h0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            wr_data_q  <= 8'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        first_d    = first_q;

        // START beats everything, including an SCL edge in the same clk.
        if (start_det) begin
            state_d  = S_ADDR;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            // General call (0x00) is never claimed.
                            if (rx_byte[7:1] == OWN_ADDR && rx_byte[7:1] != 7'd0) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d  = 1'b0;
                            bitcnt_d = 3'd0;
                            if (rw_q) begin
                                // Same fall that ends the ACK presents the read MSB.
                                state_d  = S_TX_BYTE;
                                shift_d  = cur_reg[6:0];
                                sda_oe_d = ~cur_reg[7];
                            end else begin
                                state_d  = S_RX_BYTE;
                                first_d  = 1'b1;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (first_q) begin
                                ptr_d   = rx_byte[1:0];
                                first_d = 1'b0;
                            end else begin
                                regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
                                wr_pulse_d = 1'b1;
                                wr_idx_d   = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 2'd1;
                            end
                            state_d = S_RX_ACK;
                            phase_d = 1'b0;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            bitcnt_d = 3'd0;
                            state_d  = S_RX_BYTE;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_TX_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s) begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end else begin
                            ptr_d   = ptr_q + 2'd1;
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        // ptr_q already advanced on the ACK rise.
                        state_d  = S_TX_BYTE;
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd0;
                        shift_d  = cur_reg[6:0];
                        sda_oe_d = ~cur_reg[7];
                    end
                end
                S_WAIT_STOP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign regs     = regs_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
module tb_i2c_reg_target;
    localparam int Q = 60;   // quarter SCL period in ns (SCL = 24 clks)

    logic clk = 1'b0, rst = 1'b0, scl = 1'b1, m_oe = 1'b0;
    wire  sda;
    logic [31:0] regs;
    logic        wr_pulse, busy;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_data;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    i2c_reg_target #(.OWN_ADDR(7'h51), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .regs(regs),
        .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy));

    int tests = 0, fails = 0;
    logic [9:0] cap[$];   // observed {idx,data} write strobes
    logic [9:0] expq[$];  // model-predicted strobes

    always @(negedge clk) if (wr_pulse) cap.push_back({wr_idx, wr_data});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- bus master ----------------
    task automatic wbit(input logic b);
        m_oe = ~b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    endtask
    task automatic rbit(output logic b);
        m_oe = 1'b0; #(Q); scl = 1'b1; #(Q); b = sda; #(Q); scl = 1'b0; #(Q);
    endtask
    task automatic i2c_start();
        m_oe = 1'b0; #(Q); scl = 1'b1; #(Q); m_oe = 1'b1; #(Q); scl = 1'b0; #(Q);
    endtask
    task automatic i2c_stop();
        m_oe = 1'b1; #(Q); scl = 1'b1; #(Q); m_oe = 1'b0; #(2*Q);
    endtask
    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(x);
        ack = ~x;
    endtask
    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic x;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin rbit(x); d = {d[6:0], x}; end
        wbit(~ack);
    endtask
    task automatic wr_txn(input logic [7:0] a, input int n, input logic [31:0] bs,
                          output logic aack, output logic bsy, output int dnak);
        logic k;
        dnak = 0;
        i2c_start();
        wr_byte(a, aack);
        bsy = busy;
        if (aack)
            for (int i = 0; i < n; i++) begin
                wr_byte(bs[8*i +: 8], k);
                if (!k) dnak++;
            end
        i2c_stop();
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mregs[4];
    int         mptr;
    function automatic logic [31:0] mpack();
        return {mregs[3], mregs[2], mregs[1], mregs[0]};
    endfunction
    function automatic logic m_write(input logic [7:0] a, input int n, input logic [31:0] bs);
        logic acked = (a[7:1] == 7'h51) && (a[0] == 1'b0);
        if (acked)
            for (int i = 0; i < n; i++) begin
                if (i == 0) mptr = bs[1:0];
                else begin
                    mregs[mptr] = bs[8*i +: 8];
                    expq.push_back({mptr[1:0], bs[8*i +: 8]});
                    mptr = (mptr + 1) % 4;
                end
            end
        return acked;
    endfunction
    task automatic cmp_pulses(input string nm);
        chk({nm, "_npulse"}, cap.size(), expq.size());
        for (int i = 0; i < cap.size() && i < expq.size(); i++)
            chk({nm, "_pulse"}, {22'd0, cap[i]}, {22'd0, expq[i]});
        cap.delete(); expq.delete();
    endtask

    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [31:0] bs;       // byte i at [8i+7:8i]
        logic        exp_ack;
        int          exp_pulses;
        logic [31:0] exp_regs;
    } vec_t;

    initial begin
        vec_t vt[6];
        logic a, bsy, b;
        int dn;
        logic [7:0] d;

        vt[0] = '{8'hA2, 3, 32'h00C35A01, 1'b1, 2, 32'h00C35A00};
        vt[1] = '{8'hA2, 3, 32'h00221103, 1'b1, 2, 32'h11C35A22};
        vt[2] = '{8'hA4, 2, 32'h0000FF00, 1'b0, 0, 32'h11C35A22};
        vt[3] = '{8'h00, 2, 32'h00007701, 1'b0, 0, 32'h11C35A22};
        vt[4] = '{8'hA2, 4, 32'hBEADDE00, 1'b1, 3, 32'h11BEADDE};
        vt[5] = '{8'hA2, 1, 32'h00000002, 1'b1, 0, 32'h11BEADDE};

        // reset state
        #23;
        chk("rst_regs", regs, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrp", wr_pulse, 1'b0);
        chk("rst_idx", wr_idx, 2'd0);
        chk("rst_data", wr_data, 8'd0);
        chk("rst_sda", sda, 1'b1);
        rst = 1'b1;
        #(4*Q);

        // table-driven write transactions
        for (int v = 0; v < 6; v++) begin
            cap.delete();
            wr_txn(vt[v].addr, vt[v].n, vt[v].bs, a, bsy, dn);
            chk($sformatf("v%0d_aack", v), a, vt[v].exp_ack);
            chk($sformatf("v%0d_busy_mid", v), bsy, vt[v].exp_ack);
            chk($sformatf("v%0d_dnak", v), dn, 0);
            chk($sformatf("v%0d_npulse", v), cap.size(), vt[v].exp_pulses);
            chk($sformatf("v%0d_regs", v), regs, vt[v].exp_regs);
            chk($sformatf("v%0d_busy_end", v), busy, 1'b0);
            if (v == 0 && cap.size() == 2) begin
                chk("v0_pulse0", {22'd0, cap[0]}, {22'd0, 2'd1, 8'h5A});
                chk("v0_pulse1", {22'd0, cap[1]}, {22'd0, 2'd2, 8'hC3});
            end
        end
        cap.delete();

        // pointer write, repeated START, read 3 with ACK,ACK,NACK
        i2c_start(); wr_byte(8'hA2, a); wr_byte(8'h02, a);
        i2c_start(); wr_byte(8'hA3, a);
        chk("rs_aack", a, 1'b1);
        rd_byte(d, 1'b1); chk("rs_rd0", d, 8'hBE);
        rd_byte(d, 1'b1); chk("rs_rd1", d, 8'h11);
        rd_byte(d, 1'b0); chk("rs_rd2", d, 8'hDE);
        chk("rs_sda_rel", sda, 1'b1);
        chk("rs_busy_nack", busy, 1'b0);
        i2c_stop();

        // START in the middle of a data byte
        i2c_start(); wr_byte(8'hA2, a); wr_byte(8'h01, a);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_start(); wr_byte(8'hA2, a);
        chk("mid_aack", a, 1'b1);
        wr_byte(8'h00, a);
        i2c_stop();
        chk("mid_npulse", cap.size(), 0);
        chk("mid_regs", regs, 32'h11BEADDE);
        cap.delete();

        // reset while transmitting a 0 bit (reg0 = DE, bit5 = 0)
        i2c_start(); wr_byte(8'hA3, a);
        chk("rr_aack", a, 1'b1);
        rbit(b); chk("rr_b7", b, 1'b1);
        rbit(b); chk("rr_b6", b, 1'b1);
        chk("rr_drv0", sda, 1'b0);
        rst = 1'b0; #1;
        chk("rr_sda", sda, 1'b1);
        chk("rr_busy", busy, 1'b0);
        chk("rr_regs", regs, 32'h0);
        chk("rr_wrp", wr_pulse, 1'b0);
        chk("rr_idx", wr_idx, 2'd0);
        chk("rr_data", wr_data, 8'd0);
        #40; rst = 1'b1; #(2*Q);
        i2c_start(); wr_byte(8'hA2, a);
        chk("rr_re_aack", a, 1'b1);
        i2c_stop();
        cap.delete();

        // randomized transactions against the model
        for (int k = 0; k < 4; k++) mregs[k] = 8'h00;
        mptr = 0;
        for (int it = 0; it < 14; it++) begin
            int kind = $urandom_range(0, 3);
            int n;
            logic [31:0] bs = $urandom;
            logic ea;
            if (kind <= 1) begin
                logic [7:0] ad = (kind == 0) ? 8'hA2 : {7'($urandom_range(0, 127)), 1'b0};
                n = (kind == 0) ? $urandom_range(1, 4) : 1;
                ea = m_write(ad, n, bs);
                wr_txn(ad, n, bs, a, bsy, dn);
                chk($sformatf("r%0d_aack", it), a, ea);
                chk($sformatf("r%0d_dnak", it), dn, 0);
            end else begin
                n = $urandom_range(1, 3);
                i2c_start();
                if (kind == 3) begin
                    wr_byte(8'hA2, a); wr_byte(bs[7:0], a);
                    mptr = bs[1:0];
                    i2c_start();
                end
                wr_byte(8'hA3, a);
                chk($sformatf("r%0d_raack", it), a, 1'b1);
                for (int i = 0; i < n; i++) begin
                    rd_byte(d, i != n - 1);
                    chk($sformatf("r%0d_rd%0d", it, i), d, mregs[(mptr + i) % 4]);
                end
                mptr = (mptr + n - 1) % 4;
                i2c_stop();
            end
            chk($sformatf("r%0d_regs", it), regs, mpack());
            chk($sformatf("r%0d_busy", it), busy, 1'b0);
            cmp_pulses($sformatf("r%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter OWN_ADDR, default 7'b1010001, the 7-bit target address.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA.
REQ-003 SHALL have port clk, input, 1 bit: the system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port scl, input, 1 bit: the I2C clock, externally pulled up; the block never drives it.
REQ-006 SHALL have port sda, inout, 1 bit: open-drain data line; the block drives only 0 or Z.
REQ-007 SHALL have port regs, output, 32 bits: the register file, with reg[i] at bits [8i+7:8i].
REQ-008 SHALL have port wr_pulse, output, 1 bit: one-clk strobe per register write.
REQ-009 SHALL have port wr_idx, output, 2 bits: the index of the register written, valid with wr_pulse.
REQ-010 SHALL have port wr_data, output, 8 bits: the data written, valid with wr_pulse.
REQ-011 SHALL have port busy, output, 1 bit: high while this target is addressed, from address ACK to STOP, repeated START or NACK end.

Function
REQ-012 SHALL synchronize scl/sda through SYNC_STAGES flops and detect rise/fall edges on the synchronized values.
REQ-013 SHALL detect START on synced SDA fall while SCL is high, and STOP on synced SDA rise while SCL is high.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-015 SHALL go to ADDR and clear the bit counter on START from any state, including mid-byte; this is a repeated START.
REQ-016 SHALL go to IDLE on STOP from any state, release sda and clear busy.
REQ-017 SHALL sample SDA MSB-first on each synced SCL rise in ADDR and RX_BYTE, and count bits with a 3-bit counter.
REQ-018 After the 8th ADDR bit: if addr[7:1]==OWN_ADDR, SHALL go to ADDR_ACK; otherwise SHALL go to WAIT_STOP without driving sda.
REQ-019 General-call address 0x00 SHALL NOT be acknowledged.
REQ-020 ACK timing SHALL be: pull sda low on the first SCL fall after the 8th bit, and release it on the next SCL fall.
REQ-021 After ADDR_ACK, R/W=0 SHALL lead to RX_BYTE and R/W=1 SHALL lead to TX_BYTE.
REQ-022 The first RX byte after the address SHALL load the pointer ptr=byte[1:0]; bits [7:2] are ignored and there is no wr_pulse.
REQ-023 Each later RX byte SHALL write reg[ptr], pulse wr_pulse for one clk with wr_idx=ptr and wr_data=byte, then increment ptr.
REQ-024 Every received byte SHALL be ACKed via RX_ACK, then the state returns to RX_BYTE.
REQ-025 TX_BYTE SHALL load the shift register with reg[ptr] on entry and drive sda=0 or Z on SCL falls, MSB first.
REQ-026 The first TX bit SHALL be driven on the SCL fall that ends the preceding ACK.
REQ-027 After the 8th TX bit, SHALL release sda on the SCL fall, then sample the master ACK on the SCL rise in TX_ACK.
REQ-028 In TX_ACK, ACK (0) SHALL increment ptr and return to TX_BYTE; NACK (1) SHALL go to WAIT_STOP with sda released.
REQ-029 ptr SHALL be 2 bits and wrap 3->0 on both read and write auto-increment.
REQ-030 ptr SHALL persist across transactions, so a write of the pointer only, followed by a repeated-START read, reads from that pointer.
REQ-031 WAIT_STOP SHALL ignore all SCL activity until START or STOP.
REQ-032 Same-cycle START and STOP detection is impossible by construction; if an SCL edge and START fall in the same clk, START SHALL win.
REQ-033 clk SHALL be at least 8x the SCL frequency; slower clocks are out of scope, and no clock stretching is performed.

Reset
REQ-034 On rst=0, SHALL asynchronously set state=IDLE, release sda (Z), and clear busy=0, wr_pulse=0, wr_idx=0, wr_data=0, ptr=0, regs=32'h0.
REQ-035 Synchronizer flops SHALL reset to 1 (bus idle), so reset release produces no false START.
REQ-036 Reset asserted mid-transfer SHALL release sda within the same clk, with no glitch low.

Verification
REQ-037 Write START, 0xA2, 0x01, 0x5A, 0xC3, STOP -> ACK x4, wr_pulse(idx1,5A) then (idx2,C3), regs=32'h00C35A00, busy low after STOP.
REQ-038 Write ptr 0x03, data 0x11, 0x22 -> reg3=11, then reg0=22 (wrap), ptr=1.
REQ-039 Write ptr 0x02, repeated START, 0xA3, read 3 bytes with ACK,ACK,NACK -> master reads reg2, reg3, reg0; sda released after NACK.
REQ-040 Address 0xA4 -> no ACK (sda Z on 9th SCL), busy stays 0, regs unchanged until STOP.
REQ-041 START mid-data-byte then 0xA2 -> partial byte discarded, no wr_pulse, new address ACKed.
REQ-042 rst asserted during TX of a 0 bit -> sda Z immediately, all outputs at reset values, next START/0xA2 ACKed normally.
